// File: rtl/qcw_capture_buffer.sv
// Waveform capture peripheral: stores decimated ADC samples during a QCW burst
// and returns them over the memory-mapped peripheral bus.
//
// state   | meaning
// IDLE    | waiting for ARM; buffer and COUNT hold the last capture
// ARMED   | waiting for qcw_start
// CAPTURE | storing one sample every DECIM+1 clocks
// DONE    | capture ended by qcw_cycle_done or a full buffer
module qcw_capture_buffer #(
  parameter logic [31:0] BASE_ADDR = 32'h15000000,
  parameter int          DEPTH_LOG = 9,
  parameter int          ADC_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          mem_wdata_i,
  input  logic [3:0]           mem_wstrb_i,
  output logic [31:0]          mem_rdata_o,
  input  logic [ADC_WIDTH-1:0] adc_dout,
  input  logic                 qcw_start,
  input  logic                 qcw_cycle_done,
  output logic                 capture_active
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] LAST_PTR = (DEPTH_LOG+1)'(DEPTH - 1);
  localparam logic [23:0] BUF_BASE = 24'h001000;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [ADC_WIDTH-1:0] adc_q;
  logic [ADC_WIDTH-1:0] mem [DEPTH];
  logic [ADC_WIDTH-1:0] ram_q;

  logic [DEPTH_LOG:0]   wr_ptr;
  logic [15:0]          decim_q;
  logic [15:0]          decim_cnt;
  logic [15:0]          trig_count;
  logic                 done_q;
  logic                 full_q;

  logic                 busy;
  logic                 ready_q;
  logic                 rd_buf_q;
  logic [31:0]          rdata_q;
  logic [31:0]          reg_rdata;

  logic                 sel, accept, is_wr;
  logic [23:0]          off;
  logic [21:0]          off_word;
  logic                 buf_hit;
  logic                 arm_req, abort_req, decim_wr;

  logic ram_we, clr_cap, set_done, set_full, clr_done, inc_trig;

  logic unused_bits;
  assign unused_bits = ^{mem_addr_i[1:0], mem_wstrb_i[3:2], mem_wdata_i[31:16]};

  assign sel      = mem_addr_i[31:24] == BASE_ADDR[31:24];
  assign accept   = mem_valid_i && sel && !busy;
  assign is_wr    = |mem_wstrb_i;
  assign off      = mem_addr_i[23:0];
  assign off_word = off[23:2];
  assign buf_hit  = off[23:DEPTH_LOG+2] == BUF_BASE[23:DEPTH_LOG+2];

  assign arm_req   = accept && is_wr && mem_wstrb_i[0] && off_word == 22'd0 && mem_wdata_i[0];
  assign abort_req = accept && is_wr && mem_wstrb_i[0] && off_word == 22'd0 && mem_wdata_i[1];
  assign decim_wr  = accept && is_wr && off_word == 22'd1;

  always_comb begin
    state_nxt = state;
    ram_we    = 1'b0;
    clr_cap   = 1'b0;
    set_done  = 1'b0;
    set_full  = 1'b0;
    clr_done  = 1'b0;
    inc_trig  = 1'b0;
    // ABORT outranks everything, including a simultaneous ARM
    if (abort_req) begin
      state_nxt = S_IDLE;
      clr_done  = 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm_req) begin
            state_nxt = S_ARMED;
            clr_cap   = 1'b1;
          end
        end
        S_ARMED: begin
          if (qcw_start) begin
            state_nxt = S_CAPTURE;
            ram_we    = 1'b1;
            inc_trig  = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (qcw_cycle_done) begin
            state_nxt = S_DONE;
            set_done  = 1'b1;
          end else if (decim_cnt == 16'd0) begin
            ram_we = 1'b1;
            if (wr_ptr == LAST_PTR) begin
              state_nxt = S_DONE;
              set_done  = 1'b1;
              set_full  = 1'b1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_rdata = 32'd0;
    case (off_word)
      22'd0: reg_rdata = {28'd0, full_q, done_q, state == S_CAPTURE, state == S_ARMED};
      22'd1: reg_rdata = {16'd0, decim_q};
      22'd2: reg_rdata = {{(31-DEPTH_LOG){1'b0}}, wr_ptr};
      22'd3: reg_rdata = {16'd0, trig_count};
      default: reg_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      capture_active <= 1'b0;
      adc_q          <= '0;
      wr_ptr         <= '0;
      decim_q        <= 16'd0;
      decim_cnt      <= 16'd0;
      trig_count     <= 16'd0;
      done_q         <= 1'b0;
      full_q         <= 1'b0;
    end else begin
      state          <= state_nxt;
      capture_active <= state_nxt == S_CAPTURE;
      adc_q          <= adc_dout;
      if (decim_wr) begin
        if (mem_wstrb_i[0]) decim_q[7:0]  <= mem_wdata_i[7:0];
        if (mem_wstrb_i[1]) decim_q[15:8] <= mem_wdata_i[15:8];
      end
      // decimation is a down-counter; a write happens at terminal count zero
      if (clr_cap) begin
        wr_ptr    <= '0;
        decim_cnt <= 16'd0;
        done_q    <= 1'b0;
        full_q    <= 1'b0;
      end else if (ram_we) begin
        wr_ptr    <= wr_ptr + 1'b1;
        decim_cnt <= decim_q;
      end else if (state == S_CAPTURE && decim_cnt != 16'd0) begin
        decim_cnt <= decim_cnt - 16'd1;
      end
      if (set_done) done_q <= 1'b1;
      else if (clr_done) done_q <= 1'b0;
      if (set_full) full_q <= 1'b1;
      if (inc_trig) trig_count <= trig_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_ptr[DEPTH_LOG-1:0]] <= adc_q;
    ram_q <= mem[mem_addr_i[DEPTH_LOG+1:2]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      ready_q  <= 1'b0;
      rd_buf_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      ready_q <= accept;
      if (accept) begin
        busy     <= 1'b1;
        rd_buf_q <= buf_hit && !is_wr;
        rdata_q  <= is_wr ? 32'd0 : reg_rdata;
      end else if (!mem_valid_i) begin
        busy <= 1'b0;
      end
    end
  end

  assign mem_ready_o = ready_q;
  assign mem_rdata_o = !ready_q ? 32'd0 :
                       rd_buf_q ? {{(32-ADC_WIDTH){1'b0}}, ram_q} : rdata_q;

endmodule

// File: tb/tb_qcw_capture_buffer.sv
// Directed bench for qcw_capture_buffer: register map, capture paths, abort,
// decimation, bus handshake and address decode.
module tb_qcw_capture_buffer;

  localparam logic [31:0] BASE  = 32'h15000000;
  localparam logic [31:0] CTRL  = BASE + 32'h000;
  localparam logic [31:0] DECIM = BASE + 32'h004;
  localparam logic [31:0] COUNT = BASE + 32'h008;
  localparam logic [31:0] TRIG  = BASE + 32'h00C;
  localparam logic [31:0] BUFA  = BASE + 32'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic [31:0] mem_rdata_o;
  logic [9:0]  adc_dout;
  logic        qcw_start;
  logic        qcw_cycle_done;
  logic        capture_active;

  int   checks = 0;
  int   failures = 0;
  logic ramp_en = 1'b0;

  qcw_capture_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid_i    (mem_valid_i),
    .mem_ready_o    (mem_ready_o),
    .mem_addr_i     (mem_addr_i),
    .mem_wdata_i    (mem_wdata_i),
    .mem_wstrb_i    (mem_wstrb_i),
    .mem_rdata_o    (mem_rdata_o),
    .adc_dout       (adc_dout),
    .qcw_start      (qcw_start),
    .qcw_cycle_done (qcw_cycle_done),
    .capture_active (capture_active)
  );

  always #2 clk = ~clk;

  // ADC ramp advances on the falling edge, away from the sampling edge
  always @(negedge clk) if (ramp_en) adc_dout = adc_dout + 10'd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input string tag, output logic [31:0] rdata);
    mem_valid_i = 1'b1;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    mem_wstrb_i = wstrb;
    @(posedge clk); #1;
    check({tag, "_ack"}, {31'd0, mem_ready_o}, 32'd1);
    rdata = mem_rdata_o;
    mem_valid_i = 1'b0;
    mem_wstrb_i = 4'd0;
    @(posedge clk); #1;
    check({tag, "_ackend"}, {31'd0, mem_ready_o}, 32'd0);
  endtask

  task automatic rd_chk(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    logic [31:0] d;
    bus(addr, 32'd0, 4'd0, tag, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input string tag);
    logic [31:0] d;
    bus(addr, data, strb, tag, d);
  endtask

  // hold the ADC at 0x3FF, arm; fire then starts the ramp at 0 so BUF[k] = k*(DECIM+1)-1
  task automatic arm_capture(input string tag);
    ramp_en  = 1'b0;
    adc_dout = 10'h3FF;
    wr(CTRL, 32'h1, 4'h1, tag);
  endtask

  task automatic fire();
    qcw_start = 1'b1;
    ramp_en   = 1'b1;
    @(posedge clk); #1;
    qcw_start = 1'b0;
  endtask

  initial begin
    int pulses;
    reset          = 1'b1;
    mem_valid_i    = 1'b0;
    mem_addr_i     = 32'd0;
    mem_wdata_i    = 32'd0;
    mem_wstrb_i    = 4'd0;
    adc_dout       = 10'd0;
    qcw_start      = 1'b0;
    qcw_cycle_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, mem_ready_o}, 32'd0);
    check("rst_rdata", mem_rdata_o, 32'd0);
    check("rst_active", {31'd0, capture_active}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    rd_chk(CTRL, "rst_stat", 32'd0);
    rd_chk(COUNT, "rst_count", 32'd0);
    rd_chk(TRIG, "rst_trig", 32'd0);

    // DECIM=0 capture ended by cycle_done after 100 samples
    wr(DECIM, 32'h0, 4'h3, "d0_decim");
    arm_capture("d0_arm");
    rd_chk(CTRL, "d0_armed", 32'h1);
    fire();
    repeat (99) @(posedge clk);
    #1;
    check("d0_active_hi", {31'd0, capture_active}, 32'd1);
    qcw_cycle_done = 1'b1;
    @(posedge clk); #1;
    qcw_cycle_done = 1'b0;
    check("d0_active_lo", {31'd0, capture_active}, 32'd0);
    rd_chk(CTRL, "d0_stat", 32'h4);
    rd_chk(COUNT, "d0_count", 32'd100);
    rd_chk(TRIG, "d0_trig", 32'd1);
    rd_chk(BUFA + 0, "d0_buf0", 32'h3FF);
    rd_chk(BUFA + 4, "d0_buf1", 32'd0);
    rd_chk(BUFA + 4*50, "d0_buf50", 32'd49);
    rd_chk(BUFA + 4*99, "d0_buf99", 32'd98);

    // DECIM=3 capture runs until the buffer is full
    wr(DECIM, 32'h0012_0003, 4'h3, "d3_decim");
    rd_chk(DECIM, "d3_decim_rb", 32'h3);
    arm_capture("d3_arm");
    fire();
    repeat (2043) @(posedge clk);
    #1;
    check("d3_active_hi", {31'd0, capture_active}, 32'd1);
    @(posedge clk); #1;
    check("d3_active_lo", {31'd0, capture_active}, 32'd0);
    rd_chk(CTRL, "d3_stat", 32'hC);
    rd_chk(COUNT, "d3_count", 32'd512);
    rd_chk(TRIG, "d3_trig", 32'd2);
    rd_chk(BUFA + 0, "d3_buf0", 32'h3FF);
    rd_chk(BUFA + 4, "d3_buf1", 32'd3);
    rd_chk(BUFA + 4*100, "d3_buf100", 32'd399);
    rd_chk(BUFA + 4*511, "d3_buf511", 32'h3FB);
    wr(BUFA, 32'h55, 4'hF, "buf_wr");
    rd_chk(BUFA, "buf_wr_ignored", 32'h3FF);
    rd_chk(BASE + 32'h100, "unmapped", 32'd0);

    // cycle_done on a scheduled write cycle (DECIM=1: writes at m, m+2, m+4)
    wr(DECIM, 32'h1, 4'h3, "co_decim");
    arm_capture("co_arm");
    fire();
    repeat (3) @(posedge clk);
    #1;
    qcw_cycle_done = 1'b1;
    @(posedge clk); #1;
    qcw_cycle_done = 1'b0;
    rd_chk(CTRL, "co_stat", 32'h4);
    rd_chk(COUNT, "co_count", 32'd2);
    rd_chk(BUFA + 4, "co_buf1", 32'd1);

    // ARM ignored mid-capture, then ABORT after 40 samples
    wr(DECIM, 32'h0, 4'h3, "ab_decim");
    arm_capture("ab_arm");
    fire();
    repeat (19) @(posedge clk);
    #1;
    wr(CTRL, 32'h1, 4'h1, "ab_rearm");
    repeat (18) @(posedge clk);
    #1;
    check("ab_active_hi", {31'd0, capture_active}, 32'd1);
    wr(CTRL, 32'h3, 4'h1, "ab_abort");
    check("ab_active_lo", {31'd0, capture_active}, 32'd0);
    rd_chk(CTRL, "ab_stat", 32'd0);
    rd_chk(COUNT, "ab_count", 32'd40);
    rd_chk(TRIG, "ab_trig", 32'd4);
    rd_chk(BUFA + 0, "ab_buf0", 32'h3FF);
    rd_chk(BUFA + 4*39, "ab_buf39", 32'd38);
    qcw_start = 1'b1;
    @(posedge clk); #1;
    qcw_start = 1'b0;
    check("idle_start_active", {31'd0, capture_active}, 32'd0);
    rd_chk(CTRL, "idle_start_stat", 32'd0);
    rd_chk(TRIG, "idle_start_trig", 32'd4);

    // valid held 5 cycles: exactly one ready pulse
    pulses = 0;
    mem_valid_i = 1'b1;
    mem_addr_i  = CTRL;
    mem_wstrb_i = 4'd0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ready_o) pulses++;
    end
    mem_valid_i = 1'b0;
    check("hold_pulses", pulses, 32'd1);
    @(posedge clk); #1;

    // unselected base address never acknowledges
    mem_valid_i = 1'b1;
    mem_addr_i  = 32'h1400_0000;
    repeat (4) begin
      @(posedge clk); #1;
      check("unsel_ready", {31'd0, mem_ready_o}, 32'd0);
      check("unsel_rdata", mem_rdata_o, 32'd0);
    end
    mem_valid_i = 1'b0;
    @(posedge clk); #1;

    // asynchronous reset mid-capture
    arm_capture("ar_arm");
    fire();
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("ar_active", {31'd0, capture_active}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    rd_chk(CTRL, "ar_stat", 32'd0);
    rd_chk(COUNT, "ar_count", 32'd0);
    rd_chk(TRIG, "ar_trig", 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qcw_capture_buffer.md
Name: qcw_capture_buffer

Overview:
- Memory-mapped waveform capture peripheral on the 240 MHz crossed peripheral bus, base 32'h15000000, alongside the ramp, driver, OCD and boost controllers.
- Records decimated 10-bit primary-ADC samples (the OCD current sense when the ADC mux selects it) into an on-chip buffer during each QCW burst.
- Firmware arms it, fires a burst, then reads the stored bridge-current waveform back through the clock crossing for tuning and fault diagnosis.

Parameters:
- BASE_ADDR, 32'h15000000, decode base; block selected when mem_addr_i[31:24] == BASE_ADDR[31:24].
- DEPTH_LOG, 9, log2 buffer depth in samples (512).
- ADC_WIDTH, 10, sample width.

Ports:
- clk  input  1  240 MHz peripheral clock.
- reset  input  1  asynchronous, active-high reset.
- mem_valid_i  input  1  bus request valid.
- mem_ready_o  output  1  one-cycle transaction acknowledge.
- mem_addr_i  input  32  byte address.
- mem_wdata_i  input  32  write data.
- mem_wstrb_i  input  4  byte strobes; all-zero means read.
- mem_rdata_o  output  32  read data; zero whenever not acknowledging (OR-combined bus).
- adc_dout  input  ADC_WIDTH  raw ADC sample.
- qcw_start  input  1  burst start pulse from driver control.
- qcw_cycle_done  input  1  burst finished pulse from driver.
- capture_active  output  1  high while in CAPTURE.

Behaviour:
- Reset values: mem_ready_o=0, mem_rdata_o=0, capture_active=0, state=IDLE, wr_ptr=0, decim=0, done=0, full=0, trig_count=0.
- adc_dout is registered once before use, so stored samples lag the pin by 1 cycle.
- Register map (offset from BASE_ADDR):
  - 0x000 CTRL/STAT. Write with wstrb[0]: bit0 ARM, bit1 ABORT; both self-clearing. Read: bit0 armed, bit1 capturing, bit2 done, bit3 full.
  - 0x004 DECIM. Bits[15:0] R/W; one sample stored every DECIM+1 clocks.
  - 0x008 COUNT. Read-only; samples written in the last or current capture, 0..2^DEPTH_LOG.
  - 0x00C TRIG_COUNT. Read-only 16-bit; number of bursts captured since reset, wraps at 65535->0.
  - 0x1000 + 4*i, i < 2^DEPTH_LOG: BUF, read-only {22'b0, sample[i]}; writes acknowledged and ignored.
  - Unmapped offsets read 0; writes acknowledged and ignored.
- Handshake:
  - Selected valid is acknowledged with mem_ready_o high for exactly 1 cycle, 1 cycle after valid is first seen. Registers and synchronous buffer RAM share the same latency.
  - mem_rdata_o is valid only in the ready cycle.
  - An internal busy flag blocks a second ack until mem_valid_i deasserts.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE/DONE -> ARMED on ARM write. Clears wr_ptr, done, full and the decimation counter.
  - ARMED -> CAPTURE on qcw_start=1. The first sample is written that same cycle; TRIG_COUNT increments.
  - CAPTURE: the decimation counter counts 0..DECIM. When it is 0, write the registered sample at wr_ptr and increment wr_ptr.
  - CAPTURE -> DONE on qcw_cycle_done=1; done=1, and no write occurs that cycle.
  - CAPTURE -> DONE after the write with wr_ptr == 2^DEPTH_LOG-1; full=1, done=1, COUNT=2^DEPTH_LOG.
  - If qcw_cycle_done coincides with a scheduled write, the write is skipped and the transition to DONE wins.
  - ABORT in any state -> IDLE. Buffer contents and COUNT are retained; done is cleared.
  - ARM written during CAPTURE -> ignored. ARM and ABORT in the same write -> ABORT wins.
  - qcw_start while IDLE or DONE is ignored.
- Buffer reads are permitted in any state and return current RAM contents; reads during CAPTURE may return stale or new data.
- capture_active = (state == CAPTURE), registered.
- Asynchronous reset mid-capture returns the FSM to IDLE and zeroes all counters immediately. RAM contents are undefined after reset.

Test Plan:
- Reset, then read CTRL, COUNT, TRIG_COUNT -> all read 0; each read acked 1 cycle after valid, with ready high 1 cycle only.
- DECIM=0, ARM, qcw_start, ramp adc_dout 0,1,2,..., qcw_cycle_done after 100 cycles -> STAT done=1, full=0, COUNT=100, BUF[i]=i-1 (1-cycle register lag), TRIG_COUNT=1.
- DECIM=3, ARM, start, no cycle_done for 3000 cycles -> full=1, COUNT=512, STAT done, BUF[k] equals the sample taken at cycle 4k, capture_active falls after the 512th write.
- qcw_cycle_done asserted on a scheduled write cycle -> write skipped, COUNT excludes it, state DONE.
- ABORT mid-capture after 40 samples -> STAT 0, COUNT=40, BUF[0..39] intact. A later qcw_start while IDLE is ignored.
- Read with mem_valid_i held 5 cycles -> exactly one ready pulse. An unselected address (0x14000000) -> mem_ready_o=0 and mem_rdata_o=0 throughout.
